// File: rtl/spi_flash_reader.sv
// spi_flash_reader: single-byte read cache in front of a SPI NOR flash.
// A miss halts the bus through busy. The block then either streams the next
// byte on an open read (chip select still low), or closes the old read and
// issues a fresh 0x03 READ command. SPI mode 0, with a bit period of
// 2*DIVISOR clk cycles.
module spi_flash_reader #(
  parameter int DIVISOR = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] address,
  input  logic        enable,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_do,
  input  logic        spi_di
);

  typedef enum logic [2:0] {IDLE, CS_GAP, CMD, READ, DONE} state_t;

  localparam logic [8:0] HALF     = 9'(DIVISOR);
  localparam logic [8:0] BIT_LAST = 9'(2 * DIVISOR - 1);

  state_t      state, state_next;
  logic [8:0]  cyc_cnt;
  logic [5:0]  bit_cnt;
  logic [31:0] tx_sh;
  logic [7:0]  rx_sh;
  logic [23:0] req_addr;
  logic [23:0] cached_addr;
  logic        valid;
  logic        hit;
  logic        seq;
  logic        bit_end;

  // The 25-bit compare stops 0xFFFFFF -> 0x000000 from counting as sequential.
  assign seq     = ({1'b0, address} == ({1'b0, cached_addr} + 25'd1));
  assign hit     = valid && (address == cached_addr) && (state == IDLE);
  assign bit_end = (cyc_cnt == BIT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable && !hit) begin
          if (spi_cs)             state_next = CMD;
          else if (valid && seq)  state_next = READ;
          else                    state_next = CS_GAP;
        end
      end
      CS_GAP: if (bit_end) state_next = CMD;
      CMD:    if (bit_end && bit_cnt == 6'd31) state_next = READ;
      READ:   if (bit_end && bit_cnt == 6'd7)  state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: busy halts the CPU in the same cycle as a miss; SPI clock and MOSI follow the bit timer
  always_comb begin
    busy    = (enable && !hit) || (state != IDLE);
    spi_clk = ((state == CMD) || (state == READ)) && (cyc_cnt >= HALF);
    spi_do  = (state == CMD) && tx_sh[31];
  end

  // Control: bit timer, bit counter, chip select and cache valid
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      spi_cs      <= 1'b1;
      valid       <= 1'b0;
      cached_addr <= '0;
      data_out    <= '0;
    end else begin
      if (state == CS_GAP || state == CMD || state == READ)
        cyc_cnt <= bit_end ? 9'd0 : cyc_cnt + 9'd1;
      else
        cyc_cnt <= '0;

      if (state == CMD || state == READ) begin
        if (bit_end) bit_cnt <= (state_next != state) ? 6'd0 : bit_cnt + 6'd1;
      end else begin
        bit_cnt <= '0;
      end

      // A stream keeps CS low; only a non-sequential miss on an open read raises it.
      if (state == IDLE && enable && !hit)
        spi_cs <= (state_next == CS_GAP);
      else if (state == CS_GAP && bit_end)
        spi_cs <= 1'b0;

      if (state == DONE) begin
        data_out    <= rx_sh;
        cached_addr <= req_addr;
        valid       <= 1'b1;
      end
    end
  end

  // Datapath: request latch, MOSI shifter, MISO shifter
  always_ff @(posedge clk) begin
    if (state == IDLE && enable && !hit) begin
      req_addr <= address;
      tx_sh    <= {8'h03, address};
    end else if (state == CMD && bit_end) begin
      tx_sh    <= {tx_sh[30:0], 1'b0};
    end
    // Sample MISO on the first cycle that spi_clk is high.
    if (state == READ && cyc_cnt == HALF)
      rx_sh <= {rx_sh[6:0], spi_di};
  end

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 Parameter DIVISOR, default 2: clk cycles per SPI clock half-period; legal range 1-255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 address  input  24  byte address requested by memory_bus (bank 3 / upper pages).
REQ-005 enable  input  1  read request; driven by memory_bus flash_rom_enable.
REQ-006 data_out  output  8  byte for the cached address; registered.
REQ-007 busy  output  1  combinational; memory_bus ORs it into bus_halt.
REQ-008 spi_cs  output  1  flash chip select, active low.
REQ-009 spi_clk  output  1  SPI clock, mode 0, idle low.
REQ-010 spi_do  output  1  MOSI to flash.
REQ-011 spi_di  input  1  MISO from flash.

Function
REQ-012 The block SHALL hold a one-byte cache: cached_addr (24 bits), data_out, and valid.
REQ-013 hit SHALL be valid && address == cached_addr && state == IDLE.
REQ-014 busy SHALL be (enable && !hit) || state != IDLE, so the CPU halts in the same cycle as a miss.
REQ-015 The states SHALL be IDLE, CS_GAP, CMD, READ and DONE.
REQ-016 In IDLE on enable && !hit, the block SHALL latch address into req_addr and choose the next state as follows:
- READ if spi_cs == 0 && valid && address == cached_addr + 1, with no 24-bit wrap: 0xFFFFFF -> 0x000000 is non-sequential.
- CS_GAP if spi_cs == 0 otherwise.
- CMD if spi_cs == 1.
REQ-017 CS_GAP SHALL drive spi_cs = 1 for 2*DIVISOR cycles and then enter CMD.
REQ-018 CMD SHALL drive spi_cs = 0 and shift out 32 bits MSB-first: 0x03, then req_addr[23:0].
REQ-019 READ SHALL shift in 8 bits MSB-first from spi_di.
REQ-020 Each SPI bit SHALL last 2*DIVISOR cycles:
- spi_clk low for the first DIVISOR cycles and high for the next DIVISOR cycles.
- spi_do changes only while spi_clk is low.
- spi_di is sampled on the cycle spi_clk rises.
REQ-021 DONE SHALL last one cycle. In it, data_out is loaded with the shifted byte, cached_addr with req_addr, and valid is set; the next state is IDLE.
REQ-022 spi_cs SHALL remain 0 after DONE so that sequential reads can stream; spi_clk SHALL idle at 0.
REQ-023 Changes on address or enable SHALL NOT affect a transaction already in progress; the cache is always filled for req_addr, then re-evaluated in IDLE.
REQ-024 Latency, from the enable cycle to the first cycle with busy == 0 (with enable held and the address stable):
- Cold (spi_cs == 1): 1 + 80*DIVISOR + 1 cycles.
- Non-sequential with spi_cs == 0: additional 2*DIVISOR cycles.
- Sequential: 1 + 16*DIVISOR + 1 cycles.
REQ-025 In IDLE with enable == 0, the block SHALL take no action and keep the cache contents.
REQ-026 Counters SHALL be sized to cover 32 bits and 2*255 cycles without overflow.

Reset
REQ-027 On reset, the block SHALL go to state IDLE with valid = 0, cached_addr = 0, data_out = 0x00, spi_cs = 1, spi_clk = 0 and spi_do = 0.
REQ-028 Reset SHALL take effect on the next rising edge from any state, including mid-CMD and mid-READ; the partial byte is discarded.
REQ-029 busy SHALL equal enable during reset-held cycles, because valid == 0.

Verification (DIVISOR = 2, flash model: byte = address[7:0] ^ 0x5A)
REQ-030 Cold read: after reset, enable = 1 with address 0x030010.
- MOSI carries 0x03 0x03 0x00 0x10.
- busy deasserts exactly 162 cycles after the enable edge.
- data_out = 0x4A.
REQ-031 Sequential read: after REQ-030, address 0x030011.
- No CS rise and no command is sent.
- busy is low after 34 cycles; data_out = 0x4B.
REQ-032 Hit: re-present 0x030011.
- busy = 0 in the same cycle and no SPI activity occurs.
REQ-033 Non-sequential read: after REQ-031, address 0x000200.
- spi_cs is high for 4 cycles, then a full command is sent.
- busy is low after 166 cycles; data_out = 0x5A.
REQ-034 Wrap: cache valid at 0xFFFFFF, then request 0x000000.
- The block takes the CS_GAP+CMD path, not streaming; data_out = 0x5A.
REQ-035 Reset mid-READ: assert reset during bit 4 of READ.
- The next cycle shows spi_cs = 1 and spi_clk = 0.
- valid = 0, and busy follows enable.
